// File: rtl/int_normalizer.sv
// int_normalizer
//   Registered signed-integer normalizer. A two's-complement sample is shifted
//   left until the bit below the sign bit differs from the sign bit, so that
//   redundant sign bits are removed. The shift count is returned with the
//   normalized value, so later fixed-point stages can work at full precision.
//
// Ports
//   clk        : system clock; all state updates on the rising edge
//   rst        : synchronous, active-high reset; takes priority over in_valid
//   in_valid   : qualifies in_data in this cycle
//   in_data    : signed sample to normalize (WIDTH bits)
//   out_valid  : one-cycle pulse, one cycle after each accepted sample
//   out_data   : normalized signed value (WIDTH bits)
//   out_shift  : number of left shifts applied (SHW bits)
//   out_zero   : the accepted sample was exactly zero
//
// Handshake: valid-only, with no ready and no backpressure. A sample is accepted
// on every rising edge where in_valid=1 and rst=0. Its result is presented for
// exactly that one following cycle, with out_valid=1. When no sample was accepted,
// out_valid=0 and out_data/out_shift/out_zero keep their last values.
//
// Parameters
//   WIDTH : sample width, 4..32
//   SHW   : shift-count width, 2**SHW >= WIDTH
module int_normalizer #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_shift,
  output logic             out_zero
);

  localparam logic [SHW-1:0] ONE = {{(SHW-1){1'b0}}, 1'b1};

  logic             sign;
  logic             found;
  logic [SHW-1:0]   lsc;
  logic [WIDTH-1:0] norm;
  logic             is_zero;

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d,  data_q;
  logic [SHW-1:0]   shift_d, shift_q;
  logic             zero_d,  zero_q;

  // Leading-sign detector. The scan runs down from the bit below the MSB and
  // counts the bits that match the sign, up to the first bit that differs.
  // When every bit matches (the inputs 0 and -1), the count reaches WIDTH-1.
  // The shifter then gives 0 for the input 0 and the most negative value for -1,
  // so these two cases need no special handling.
  always_comb begin
    sign  = in_data[WIDTH-1];
    lsc   = '0;
    found = 1'b0;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      if (!found) begin
        if (in_data[i] == sign) begin
          lsc = lsc + ONE;
        end else begin
          found = 1'b1;
        end
      end
    end
    norm    = in_data << lsc;
    is_zero = (in_data == '0);
  end

  // Output stage: the result loads only for an accepted sample; otherwise it holds.
  always_comb begin
    valid_d = in_valid;
    data_d  = data_q;
    shift_d = shift_q;
    zero_d  = zero_q;
    if (in_valid) begin
      data_d  = norm;
      shift_d = lsc;
      zero_d  = is_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      shift_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      shift_q <= shift_d;
      zero_q  <= zero_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_shift = shift_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_int_normalizer.sv
// tb_int_normalizer
//   Bench for int_normalizer with WIDTH=16 and SHW=4. The driver pushes the
//   expected result of each accepted sample onto a queue. A monitor on the
//   falling edge compares out_valid on every cycle. It pops the queue whenever
//   a result is due, and compares the held outputs during idle and reset cycles.
module tb_int_normalizer;

  localparam int W     = 16;
  localparam int SHW   = 4;
  localparam int ENT_W = W + 1 + SHW + W;  // {x, zero, shift, data}

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SHW-1:0] out_shift;
  logic           out_zero;

  int n_checks = 0;
  int n_pass   = 0;

  logic [ENT_W-1:0] exp_q[$];

  int_normalizer #(.WIDTH(W), .SHW(SHW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_shift (out_shift),
    .out_zero  (out_zero)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: repeatedly shift while the top two bits agree.
  function automatic logic [ENT_W-1:0] ref_norm(input logic [W-1:0] x);
    logic [W-1:0]   v;
    logic [SHW-1:0] s;
    v = x;
    s = '0;
    for (int k = 0; k < W - 1; k++) begin
      if (v[W-1] == v[W-2]) begin
        v = v << 1;
        s = s + 1'b1;
      end
    end
    return {x, (x == '0), s, v};
  endfunction

  // ---------------- drivers ----------------
  // Drive one valid sample with an explicitly given expected result.
  task automatic drive_exp(input logic [W-1:0] x, input logic [W-1:0] e_data,
                           input logic [SHW-1:0] e_shift, input logic e_zero);
    in_valid = 1'b1;
    in_data  = x;
    exp_q.push_back({x, e_zero, e_shift, e_data});
    @(posedge clk);
    #1;
  endtask

  // Drive one valid sample whose expected result comes from the model.
  task automatic drive_model(input logic [W-1:0] x);
    in_valid = 1'b1;
    in_data  = x;
    exp_q.push_back(ref_norm(x));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [W-1:0] junk);
    in_valid = 1'b0;
    in_data  = junk;
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic             mon_en  = 1'b0;
  logic             exp_v   = 1'b0;
  logic             exp_rst = 1'b0;
  logic [W-1:0]     hold_data;
  logic [SHW-1:0]   hold_shift;
  logic             hold_zero;
  logic [ENT_W-1:0] ent;
  logic [W-1:0]     ent_x;
  logic [W-1:0]     back;

  always @(posedge clk) begin
    exp_rst = rst;
    exp_v   = in_valid && !rst;
    if (rst) mon_en = 1'b1;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
      if (exp_rst) begin
        hold_data  = '0;
        hold_shift = '0;
        hold_zero  = 1'b0;
      end else if (exp_v) begin
        check("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          ent = exp_q.pop_front();
          {ent_x, hold_zero, hold_shift, hold_data} = ent;
          if (ent_x != '0) begin
            back = $signed(out_data) >>> out_shift;
            check("reconstruct", {16'd0, back}, {16'd0, ent_x});
            check("sign_keep", {31'd0, out_data[W-1]}, {31'd0, ent_x[W-1]});
            check("normalized", {31'd0, out_data[W-1] ^ out_data[W-2]}, 32'd1);
          end
        end
      end
      check("out_data", {16'd0, out_data}, {16'd0, hold_data});
      check("out_shift", {28'd0, out_shift}, {28'd0, hold_shift});
      check("out_zero", {31'd0, out_zero}, {31'd0, hold_zero});
    end
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] r16;
  int           rs;

  initial begin
    // Reset held two cycles with a live-looking sample that must be discarded.
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h1234;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic sequence.
    drive_exp(16'hFFFF, 16'h8000, 4'd15, 1'b0);
    drive_exp(16'h0000, 16'h0000, 4'd15, 1'b1);
    drive_exp(16'h0001, 16'h4000, 4'd14, 1'b0);
    // Negative magnitudes.
    drive_exp(16'hFF01, 16'h8080, 4'd7,  1'b0);
    drive_exp(16'hFFF8, 16'h8000, 4'd12, 1'b0);
    drive_exp(16'hFF00, 16'h8000, 4'd7,  1'b0);
    // Positive magnitudes.
    drive_exp(16'h00FA, 16'h7D00, 4'd7,  1'b0);
    drive_exp(16'h0007, 16'h7000, 4'd12, 1'b0);
    drive_exp(16'h4000, 16'h4000, 4'd0,  1'b0);
    // Already normalized and extremes.
    drive_exp(16'h8000, 16'h8000, 4'd0,  1'b0);
    drive_exp(16'h7FFF, 16'h7FFF, 4'd0,  1'b0);
    drive_exp(16'hC000, 16'h8000, 4'd1,  1'b0);

    // Valid gating: alternating valid/idle with changing data.
    for (int i = 0; i < 8; i++) begin
      r16 = 16'($urandom);
      drive_model(r16);
      idle(16'($urandom));
    end
    idle(16'h5555);
    idle(16'hAAAA);

    // Mid-run reset with a sample present, then resume.
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h0003;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_model(16'h0003);

    // Random samples with a spread of magnitudes and random idle gaps.
    for (int i = 0; i < 10000; i++) begin
      rs  = $urandom_range(0, 15);
      r16 = 16'($urandom);
      r16 = $signed(r16) >>> rs;
      if ($urandom_range(0, 3) == 0) idle(16'($urandom));
      drive_model(r16);
    end

    // Drain, bounded.
    in_valid = 1'b0;
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    check("drain", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/int_normalizer.md
Name: int_normalizer

Overview:
- Registered signed-integer normalizer for the audio datapath.
- Takes a two's-complement sample and left-shifts it until the first bit after the sign bit differs from the sign bit (redundant sign bits removed).
- Returns the normalized value and the shift count, so downstream fixed-point blocks (gain, divide, visualization scaling) work at full precision.
- Single clock domain, one-cycle latency, valid-qualified.

Parameters:
- WIDTH, 16, sample width in bits (signed two's complement); legal range 4..32.
- SHW, 4, shift-count width; must satisfy 2^SHW >= WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies in_data this cycle.
- in_data  input  WIDTH  signed sample to normalize.
- out_valid  output  1  high one cycle after an accepted in_valid.
- out_data  output  WIDTH  normalized signed value.
- out_shift  output  SHW  number of left shifts applied.
- out_zero  output  1  input was exactly 0.

Behaviour:
- Reset: when rst is high at a rising edge, out_valid=0, out_data=0, out_shift=0, out_zero=0. Reset has priority over in_valid. A sample presented in the same cycle as reset is discarded.
- Latency: exactly 1 cycle. A sample accepted at edge N (in_valid=1) produces outputs valid after edge N; out_valid pulses for one cycle per accepted sample.
- Throughput: one sample per cycle, no backpressure. Back-to-back samples are produced back-to-back.
- When in_valid=0: out_valid=0 on the next cycle; out_data, out_shift and out_zero hold their previous values.
- Shift count, for a nonzero input x:
  - s = (number of consecutive bits below the MSB equal to the MSB) = leading-sign-bit count minus 1.
  - out_shift = s; out_data = (x << s) truncated to WIDTH bits.
  - Result guarantee: out_data[WIDTH-1] == x[WIDTH-1] and out_data[WIDTH-2] != out_data[WIDTH-1].
  - The shift is purely logical; zeros fill from the LSB. No rounding, no saturation, no sign change.
- Special cases:
  - x = 0: out_data=0, out_shift=WIDTH-1, out_zero=1.
  - x = -1 (all ones): out_data = 1000..0 (most negative), out_shift=WIDTH-1, out_zero=0.
  - x = most negative (100..0) or any x with bits [W-1] and [W-2] already differing: out_shift=0, out_data=x.
  - Only the x = 0 case sets out_zero=1.
- Implementation: a combinational leading-sign detector (priority encoder or log-tree) plus a barrel shifter feeding one output register stage. All outputs are registered; there are no combinational paths from input to output.

Test Plan:
- Reset: assert rst 2 cycles while in_valid=1, in_data=0x1234 -> out_valid=0, out_data=0, out_shift=0, out_zero=0 throughout; first sample after release is processed normally.
- Basic sequence (WIDTH=16): in_data -1, 0, 1 on consecutive valid cycles -> outputs one cycle later:
  - -1 -> 0x8000 / shift 15 / zero 0
  - 0 -> 0x0000 / shift 15 / zero 1
  - 1 -> 0x4000 / shift 14 / zero 0
- Negative magnitudes: -255 (0xFF01) -> 0x8080 / shift 7; -8 (0xFFF8) -> 0x8000 / shift 12; -256 (0xFF00) -> 0x8000 / shift 7.
- Positive magnitudes: 250 (0x00FA) -> 0x7D00 / shift 7; 7 -> 0x7000 / shift 12; 0x4000 -> 0x4000 / shift 0.
- Already normalized / extremes: 0x8000 -> 0x8000 / shift 0; 0x7FFF -> 0x7FFF / shift 0; 0xC000 -> 0x8000 / shift 1.
- Valid gating: alternate in_valid 1/0 with changing in_data -> out_valid mirrors in_valid delayed 1 cycle; outputs hold during idle cycles; random 10k-sample check against a reference model verifies the result guarantee and x == out_data >>> out_shift (arithmetic) for all nonzero x.
